multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- FSM-based controller for the multi-cycle RV32I datapath; successor to the single-cycle combinational control unit.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Supports variable-latency instruction and data memories through req/ready handshakes, with a parametrised timeout.
- Fixes branch decode: BGE/BGEU are taken on !BrLt only; BrUn is driven whenever the branch is unsigned.
- Reports illegal instructions and bus timeouts as a sticky trap.

Parameters:
- ALUSEL_W, 4, width of ALUSel (encodings unchanged: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 auipc-add, 11 lui-pass).
- IMMSEL_W, 3, width of ImmSel (0 I, 1 U, 2 S, 3 B, 4 J).
- TIMEOUT_CYCLES, 16, cycles req may wait for ready before a trap; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- opcode  in  5  instr[6:2], taken from the IR.
- func_3  in  3  instr[14:12].
- func_7  in  1  instr[30].
- BrEq  in  1  branch comparator: equal.
- BrLt  in  1  branch comparator: less than.
- imem_ready  in  1  instruction memory: data valid / accept.
- dmem_ready  in  1  data memory: access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- IRWrite  out  1  load the IR.
- PCWrite  out  1  update the PC.
- PCSel  out  1  0 = PC+4, 1 = ALU result.
- ImmSel  out  IMMSEL_W  immediate format select.
- BrUn  out  1  unsigned compare.
- ASel  out  1  0 = rs1, 1 = PC.
- BSel  out  1  0 = rs2, 1 = immediate.
- ALUSel  out  ALUSEL_W  ALU operation.
- MemRW  out  1  1 = store.
- RegWEn  out  1  register file write enable.
- WBSel  out  2  0 = mem, 1 = ALU, 2 = PC+4.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  0 none, 1 illegal, 2 imem timeout, 3 dmem timeout.
- state_o  out  3  current state, for debug.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. Reset forces state=BOOT, wait counter=0, decoded-control register=0, trap=0, trap_cause=0.
- Outputs are combinational from state, the decoded-control register and the handshake inputs. In BOOT every output is 0.
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- BOOT: always goes to FETCH on the next cycle.
- FETCH:
  - imem_req=1 until imem_ready is sampled high.
  - IRWrite=1 in the cycle imem_ready=1; next state DECODE.
- DECODE:
  - Registers the decoded control fields from opcode, func_3 and func_7.
  - An unsupported opcode or func_3 goes to TRAP with cause 1. JALR requires func_3=000.
  - Otherwise next state EXEC.
- EXEC:
  - Drives ASel, BSel, ImmSel, ALUSel and BrUn per the decoded op.
  - ALU/LUI/AUIPC/JAL/JALR → WB.
  - Load/store → MEM.
  - Branch:
    - PCWrite=1; PCSel=taken; next state FETCH.
    - BEQ taken = BrEq; BNE taken = !BrEq.
    - BLT/BLTU taken = BrLt; BGE/BGEU taken = !BrLt.
    - BrUn=1 for BLTU/BGEU in every branch cycle.
- MEM:
  - dmem_req=1 and MemRW=store. ALU controls are held, so the address stays stable.
  - On dmem_ready: load → WB; store → PCWrite=1, PCSel=0, next state FETCH.
- WB:
  - RegWEn=1 and PCWrite=1, both for exactly one cycle; next state FETCH.
  - WBSel: load 0, ALU 1, JAL/JALR 2.
  - PCSel=1 for JAL/JALR, with the ALU computing the target: JAL uses ASel=1, ImmSel=4; JALR uses ASel=0, ImmSel=0. PCSel=0 otherwise.
- Minimum latencies with zero-wait memory: branch 3 cycles, store 4, ALU/jump 4, load 5.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle that req=1 and ready=0.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with ready still 0 → TRAP with cause 2 (FETCH) or 3 (MEM).
  - If ready arrives in the same cycle the limit is reached, ready wins.
- TRAP: all strobes and requests are 0, trap=1 and trap_cause holds its value. The FSM stays in TRAP until reset.
- Asserting rst mid-transaction drops imem_req/dmem_req immediately, without waiting for a clock edge. No write strobe may pulse.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state_t enum;
  - the ALUSel/ImmSel/WBSel localparams;
  - opcode constants (LOAD 00000, OPIMM 00100, AUIPC 00101, STORE 01000, OP 01100, LUI 01101, BRANCH 11000, JALR 11001, JAL 11011);
  - packed struct ctrl_t {alu_sel, imm_sel, a_sel, b_sel, wb_sel, br_un, is_load, is_store, is_branch, is_jump, legal}.
- One combinational sub-module, mc_decode: inputs opcode, func_3, func_7; output ctrl_t.
- The FSM, wait counter and trap logic stay in the top module.

Test Plan:
- ADD (01100/000/0) with imem_ready=1: states BOOT→FETCH→DECODE→EXEC→WB→FETCH. ALUSel=0 in EXEC. RegWEn=1, WBSel=1, PCWrite=1 in WB only.
- LW (00000/010) with dmem_ready delayed 3 cycles: dmem_req high for 4 cycles, MemRW=0, BSel=1. Then WB with WBSel=0 and RegWEn=1 for one cycle.
- Branches:
  - BEQ with BrEq=1: PCWrite=1, PCSel=1, ImmSel=3 in EXEC.
  - BEQ with BrEq=0: PCSel=0.
  - BGEU with BrLt=0: taken, BrUn=1.
  - BGE with BrLt=1, BrEq=0: not taken.
- Illegal opcode 11111: TRAP, trap_cause=1. imem_req stays 0 for 20 or more cycles until rst.
- TIMEOUT_CYCLES=8 with imem_ready held 0: TRAP after 8 wait cycles, trap_cause=2. Repeat with dmem_ready held 0 on SW: trap_cause=3.
- rst asserted mid-MEM of SW: dmem_req falls asynchronously, with no MemRW/PCWrite pulse. After release, BOOT then FETCH on the next cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Holds the FSM states, the control-field encodings, the opcodes and the decoded-control payload.
package mc_ctrl_pkg;

   localparam int unsigned CTRL_ALU_W = 4;
   localparam int unsigned CTRL_IMM_W = 3;
   localparam int unsigned CTRL_WB_W  = 2;

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [CTRL_ALU_W-1:0] ALU_ADD   = 4'd0;
   localparam logic [CTRL_ALU_W-1:0] ALU_SUB   = 4'd1;
   localparam logic [CTRL_ALU_W-1:0] ALU_AND   = 4'd2;
   localparam logic [CTRL_ALU_W-1:0] ALU_OR    = 4'd3;
   localparam logic [CTRL_ALU_W-1:0] ALU_XOR   = 4'd4;
   localparam logic [CTRL_ALU_W-1:0] ALU_SLL   = 4'd5;
   localparam logic [CTRL_ALU_W-1:0] ALU_SRL   = 4'd6;
   localparam logic [CTRL_ALU_W-1:0] ALU_SRA   = 4'd7;
   localparam logic [CTRL_ALU_W-1:0] ALU_SLT   = 4'd8;
   localparam logic [CTRL_ALU_W-1:0] ALU_SLTU  = 4'd9;
   localparam logic [CTRL_ALU_W-1:0] ALU_AUIPC = 4'd10;
   localparam logic [CTRL_ALU_W-1:0] ALU_LUI   = 4'd11;

   localparam logic [CTRL_IMM_W-1:0] IMM_I = 3'd0;
   localparam logic [CTRL_IMM_W-1:0] IMM_U = 3'd1;
   localparam logic [CTRL_IMM_W-1:0] IMM_S = 3'd2;
   localparam logic [CTRL_IMM_W-1:0] IMM_B = 3'd3;
   localparam logic [CTRL_IMM_W-1:0] IMM_J = 3'd4;

   localparam logic [CTRL_WB_W-1:0] WB_MEM = 2'd0;
   localparam logic [CTRL_WB_W-1:0] WB_ALU = 2'd1;
   localparam logic [CTRL_WB_W-1:0] WB_PC4 = 2'd2;

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
   localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

   typedef struct packed {
      logic [CTRL_ALU_W-1:0] alu_sel;
      logic [CTRL_IMM_W-1:0] imm_sel;
      logic                  a_sel;
      logic                  b_sel;
      logic [CTRL_WB_W-1:0]  wb_sel;
      logic                  br_un;
      logic                  is_load;
      logic                  is_store;
      logic                  is_branch;
      logic                  is_jump;
      logic                  legal;
   } ctrl_t;

   // sub_ok selects SUB/SRA on instr[30]; OP-IMM only honours it for the shift-right case
   function automatic logic [CTRL_ALU_W-1:0] alu_from_f3(input logic [2:0] f3, input logic f7,
                                                         input logic sub_ok);
      logic [CTRL_ALU_W-1:0] sel;
      case (f3)
         3'b000:  sel = (f7 && sub_ok) ? ALU_SUB : ALU_ADD;
         3'b001:  sel = ALU_SLL;
         3'b010:  sel = ALU_SLT;
         3'b011:  sel = ALU_SLTU;
         3'b100:  sel = ALU_XOR;
         3'b101:  sel = f7 ? ALU_SRA : ALU_SRL;
         3'b110:  sel = ALU_OR;
         default: sel = ALU_AND;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/func_3/func_7 to the control payload.
// LUI, AUIPC and JAL ignore func_3, which is part of their immediate.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [4:0] opcode,
   input  logic [2:0] func_3,
   input  logic       func_7,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (opcode)
         OPC_LOAD: begin
            ctrl.legal   = (func_3 != 3'b011) && (func_3 != 3'b110) && (func_3 != 3'b111);
            ctrl.alu_sel = ALU_ADD;
            ctrl.imm_sel = IMM_I;
            ctrl.b_sel   = 1'b1;
            ctrl.wb_sel  = WB_MEM;
            ctrl.is_load = 1'b1;
         end
         OPC_STORE: begin
            ctrl.legal    = (func_3 == 3'b000) || (func_3 == 3'b001) || (func_3 == 3'b010);
            ctrl.alu_sel  = ALU_ADD;
            ctrl.imm_sel  = IMM_S;
            ctrl.b_sel    = 1'b1;
            ctrl.is_store = 1'b1;
         end
         OPC_OPIMM: begin
            ctrl.legal   = !((func_3 == 3'b001) && func_7);
            ctrl.alu_sel = alu_from_f3(func_3, func_7, 1'b0);
            ctrl.imm_sel = IMM_I;
            ctrl.b_sel   = 1'b1;
            ctrl.wb_sel  = WB_ALU;
         end
         OPC_OP: begin
            ctrl.legal   = !func_7 || (func_3 == 3'b000) || (func_3 == 3'b101);
            ctrl.alu_sel = alu_from_f3(func_3, func_7, 1'b1);
            ctrl.wb_sel  = WB_ALU;
         end
         OPC_LUI, OPC_AUIPC: begin
            ctrl.legal   = 1'b1;
            ctrl.alu_sel = (opcode == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
            ctrl.a_sel   = (opcode == OPC_AUIPC);
            ctrl.imm_sel = IMM_U;
            ctrl.b_sel   = 1'b1;
            ctrl.wb_sel  = WB_ALU;
         end
         OPC_BRANCH: begin
            ctrl.legal     = (func_3 != 3'b010) && (func_3 != 3'b011);
            ctrl.alu_sel   = ALU_ADD;
            ctrl.imm_sel   = IMM_B;
            ctrl.a_sel     = 1'b1;
            ctrl.b_sel     = 1'b1;
            ctrl.br_un     = func_3[1];
            ctrl.is_branch = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            ctrl.legal   = (opcode == OPC_JAL) || (func_3 == 3'b000);
            ctrl.alu_sel = ALU_ADD;
            ctrl.imm_sel = (opcode == OPC_JAL) ? IMM_J : IMM_I;
            ctrl.a_sel   = (opcode == OPC_JAL);
            ctrl.b_sel   = 1'b1;
            ctrl.wb_sel  = WB_PC4;
            ctrl.is_jump = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: FETCH/DECODE/EXEC/MEM/WB sequencing with memory handshakes,
// bus-wait timeout and a sticky trap. Outputs are combinational from state and decoded control.
module multicycle_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned ALUSEL_W       = 4,
   parameter int unsigned IMMSEL_W       = 3,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4:0]          opcode,
   input  logic [2:0]          func_3,
   input  logic                func_7,
   input  logic                BrEq,
   input  logic                BrLt,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                imem_req,
   output logic                dmem_req,
   output logic                IRWrite,
   output logic                PCWrite,
   output logic                PCSel,
   output logic [IMMSEL_W-1:0] ImmSel,
   output logic                BrUn,
   output logic                ASel,
   output logic                BSel,
   output logic [ALUSEL_W-1:0] ALUSel,
   output logic                MemRW,
   output logic                RegWEn,
   output logic [1:0]          WBSel,
   output logic                trap,
   output logic [1:0]          trap_cause,
   output logic [2:0]          state_o
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_q, ctrl_dec;
   logic             trap_q, trap_d;
   logic [1:0]       cause_q, cause_d;
   logic             timeout_hit;
   logic             br_taken;

   mc_decode u_decode (
      .opcode (opcode),
      .func_3 (func_3),
      .func_7 (func_7),
      .ctrl   (ctrl_dec)
   );

   // Limit is checked on the registered count, so ready in the limit cycle still wins
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
   assign br_taken    = (func_3[2] ? BrLt : BrEq) ^ func_3[0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      trap_d   = trap_q;
      cause_d  = cause_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSel    = 1'b0;
      ImmSel   = '0;
      BrUn     = 1'b0;
      ASel     = 1'b0;
      BSel     = 1'b0;
      ALUSel   = '0;
      MemRW    = 1'b0;
      RegWEn   = 1'b0;
      WBSel    = '0;

      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         ASel   = ctrl_q.a_sel;
         BSel   = ctrl_q.b_sel;
         ImmSel = IMMSEL_W'(ctrl_q.imm_sel);
         ALUSel = ALUSEL_W'(ctrl_q.alu_sel);
      end

      case (state_q)
         S_BOOT: state_d = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               IRWrite = 1'b1;
               state_d = S_DECODE;
            end else if (timeout_hit) begin
               state_d = S_TRAP;
               cause_d = CAUSE_IMEM_TO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DECODE: begin
            if (ctrl_dec.legal) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         S_EXEC: begin
            BrUn = ctrl_q.is_branch && ctrl_q.br_un;
            if (!ctrl_q.legal) begin
               state_d = S_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else if (ctrl_q.is_branch) begin
               PCWrite = 1'b1;
               PCSel   = br_taken;
               state_d = S_FETCH;
            end else if (ctrl_q.is_load || ctrl_q.is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            MemRW    = ctrl_q.is_store;
            if (dmem_ready) begin
               if (ctrl_q.is_store) begin
                  PCWrite = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (timeout_hit) begin
               state_d = S_TRAP;
               cause_d = CAUSE_DMEM_TO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            RegWEn  = 1'b1;
            PCWrite = 1'b1;
            WBSel   = ctrl_q.wb_sel;
            PCSel   = ctrl_q.is_jump;
            state_d = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_BOOT;
      endcase

      if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) begin
         cnt_d = '0;
      end
      if (state_d == S_TRAP) begin
         trap_d = 1'b1;
      end

      // Reset kills requests and strobes without waiting for the state register
      if (rst) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         MemRW    = 1'b0;
         RegWEn   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_BOOT;
         cnt_q   <= '0;
         ctrl_q  <= '0;
         trap_q  <= 1'b0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trap_q  <= trap_d;
         cause_q <= cause_d;
         if (state_q == S_DECODE) begin
            ctrl_q <= ctrl_dec;
         end
      end
   end

   assign trap       = trap_q;
   assign trap_cause = cause_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (timeout set to 8 cycles).
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] opcode;
   logic [2:0] func_3;
   logic       func_7, BrEq, BrLt, imem_ready, dmem_ready;
   logic       imem_req, dmem_req, IRWrite, PCWrite, PCSel, BrUn, ASel, BSel, MemRW, RegWEn, trap;
   logic [2:0] ImmSel;
   logic [3:0] ALUSel;
   logic [1:0] WBSel, trap_cause;
   logic [2:0] state_o;

   int checks = 0;
   int errors = 0;

   multicycle_control_unit #(
      .ALUSEL_W(4), .IMMSEL_W(3), .TIMEOUT_CYCLES(8), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func_3(func_3), .func_7(func_7),
      .BrEq(BrEq), .BrLt(BrLt), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCSel(PCSel), .ImmSel(ImmSel), .BrUn(BrUn), .ASel(ASel), .BSel(BSel),
      .ALUSel(ALUSel), .MemRW(MemRW), .RegWEn(RegWEn), .WBSel(WBSel), .trap(trap),
      .trap_cause(trap_cause), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset, then run the given instruction with zero-wait fetch up to the cycle after DECODE
   task automatic start(input logic [4:0] op, input logic [2:0] f3, input logic f7);
      rst = 1'b1;
      opcode = op; func_3 = f3; func_7 = f7;
      imem_ready = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; opcode = '0; func_3 = '0; func_7 = 1'b0;
      BrEq = 1'b0; BrLt = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      tick();
      checks++;
      if (state_o !== 3'd0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: state=%0d trap=%0b cause=%0d, expected 0/0/0", state_o, trap, trap_cause);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({imem_req, dmem_req, IRWrite, PCWrite, RegWEn, MemRW} !== 6'd0) begin
         errors++;
         $display("FAIL boot_outputs: strobes=%b expected 000000", {imem_req, dmem_req, IRWrite, PCWrite, RegWEn, MemRW});
      end
      tick();
      checks++;
      if (state_o !== 3'd1 || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL boot_to_fetch: state=%0d imem_req=%0b expected 1/1", state_o, imem_req);
      end
   endtask

   task automatic test_add();
      rst = 1'b1; opcode = 5'b01100; func_3 = 3'b000; func_7 = 1'b0; imem_ready = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (state_o !== 3'd1 || IRWrite !== 1'b1) begin
         errors++;
         $display("FAIL add_fetch: state=%0d IRWrite=%0b expected 1/1", state_o, IRWrite);
      end
      tick();
      checks++;
      if (state_o !== 3'd2) begin
         errors++;
         $display("FAIL add_decode: state=%0d expected 2", state_o);
      end
      tick();
      checks++;
      if (state_o !== 3'd3 || ALUSel !== 4'd0 || RegWEn !== 1'b0 || PCWrite !== 1'b0) begin
         errors++;
         $display("FAIL add_exec: state=%0d ALUSel=%0d RegWEn=%0b PCWrite=%0b expected 3/0/0/0", state_o, ALUSel, RegWEn, PCWrite);
      end
      tick();
      checks++;
      if (state_o !== 3'd5 || RegWEn !== 1'b1 || WBSel !== 2'd1 || PCWrite !== 1'b1 || PCSel !== 1'b0) begin
         errors++;
         $display("FAIL add_wb: state=%0d RegWEn=%0b WBSel=%0d PCWrite=%0b PCSel=%0b expected 5/1/1/1/0", state_o, RegWEn, WBSel, PCWrite, PCSel);
      end
      tick();
      checks++;
      if (state_o !== 3'd1 || RegWEn !== 1'b0) begin
         errors++;
         $display("FAIL add_back_to_fetch: state=%0d RegWEn=%0b expected 1/0", state_o, RegWEn);
      end
   endtask

   task automatic test_alu_ops();
      start(5'b01100, 3'b000, 1'b1);
      checks++;
      if (ALUSel !== 4'd1 || BSel !== 1'b0) begin
         errors++;
         $display("FAIL sub_exec: ALUSel=%0d BSel=%0b expected 1/0", ALUSel, BSel);
      end
      start(5'b00100, 3'b101, 1'b1);
      checks++;
      if (ALUSel !== 4'd7 || BSel !== 1'b1 || ImmSel !== 3'd0) begin
         errors++;
         $display("FAIL srai_exec: ALUSel=%0d BSel=%0b ImmSel=%0d expected 7/1/0", ALUSel, BSel, ImmSel);
      end
      start(5'b00101, 3'b110, 1'b0);
      checks++;
      if (ALUSel !== 4'd10 || ASel !== 1'b1 || ImmSel !== 3'd1) begin
         errors++;
         $display("FAIL auipc_exec: ALUSel=%0d ASel=%0b ImmSel=%0d expected 10/1/1", ALUSel, ASel, ImmSel);
      end
   endtask

   task automatic test_load();
      int bad = 0;
      dmem_ready = 1'b0;
      start(5'b00000, 3'b010, 1'b0);
      checks++;
      if (BSel !== 1'b1 || ALUSel !== 4'd0 || state_o !== 3'd3) begin
         errors++;
         $display("FAIL lw_exec: BSel=%0b ALUSel=%0d state=%0d expected 1/0/3", BSel, ALUSel, state_o);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) dmem_ready = 1'b1;
         #1;
         if (state_o !== 3'd4 || dmem_req !== 1'b1 || MemRW !== 1'b0 || BSel !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL lw_mem_wait: bad_cycles=%0d expected 0", bad);
      end
      tick();
      dmem_ready = 1'b0;
      checks++;
      if (state_o !== 3'd5 || WBSel !== 2'd0 || RegWEn !== 1'b1 || dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL lw_wb: state=%0d WBSel=%0d RegWEn=%0b dmem_req=%0b expected 5/0/1/0", state_o, WBSel, RegWEn, dmem_req);
      end
      tick();
      checks++;
      if (state_o !== 3'd1 || RegWEn !== 1'b0) begin
         errors++;
         $display("FAIL lw_wb_once: state=%0d RegWEn=%0b expected 1/0", state_o, RegWEn);
      end
   endtask

   task automatic test_store();
      dmem_ready = 1'b1;
      start(5'b01000, 3'b010, 1'b0);
      checks++;
      if (ImmSel !== 3'd2 || BSel !== 1'b1) begin
         errors++;
         $display("FAIL sw_exec: ImmSel=%0d BSel=%0b expected 2/1", ImmSel, BSel);
      end
      tick();
      checks++;
      if (state_o !== 3'd4 || MemRW !== 1'b1 || PCWrite !== 1'b1 || PCSel !== 1'b0 || RegWEn !== 1'b0) begin
         errors++;
         $display("FAIL sw_mem: state=%0d MemRW=%0b PCWrite=%0b PCSel=%0b RegWEn=%0b expected 4/1/1/0/0", state_o, MemRW, PCWrite, PCSel, RegWEn);
      end
      tick();
      checks++;
      if (state_o !== 3'd1) begin
         errors++;
         $display("FAIL sw_to_fetch: state=%0d expected 1", state_o);
      end
      dmem_ready = 1'b0;
   endtask

   task automatic test_branch();
      logic [2:0] f3 [5] = '{3'b000, 3'b000, 3'b111, 3'b101, 3'b110};
      logic       eq [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       lt [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       tk [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic       un [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         BrEq = eq[i]; BrLt = lt[i];
         start(5'b11000, f3[i], 1'b0);
         checks++;
         if (state_o !== 3'd3 || PCWrite !== 1'b1 || PCSel !== tk[i] || BrUn !== un[i] || ImmSel !== 3'd3) begin
            errors++;
            $display("FAIL branch_%0d: state=%0d PCWrite=%0b PCSel=%0b BrUn=%0b ImmSel=%0d expected 3/1/%0b/%0b/3",
                     i, state_o, PCWrite, PCSel, BrUn, ImmSel, tk[i], un[i]);
         end
         tick();
         checks++;
         if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL branch_%0d_fetch: state=%0d expected 1", i, state_o);
         end
      end
      BrEq = 1'b0; BrLt = 1'b0;
   endtask

   task automatic test_jumps();
      start(5'b11011, 3'b010, 1'b0);
      tick();
      checks++;
      if (state_o !== 3'd5 || PCSel !== 1'b1 || ASel !== 1'b1 || ImmSel !== 3'd4 || WBSel !== 2'd2) begin
         errors++;
         $display("FAIL jal_wb: state=%0d PCSel=%0b ASel=%0b ImmSel=%0d WBSel=%0d expected 5/1/1/4/2", state_o, PCSel, ASel, ImmSel, WBSel);
      end
      start(5'b11001, 3'b000, 1'b0);
      tick();
      checks++;
      if (state_o !== 3'd5 || PCSel !== 1'b1 || ASel !== 1'b0 || ImmSel !== 3'd0 || WBSel !== 2'd2) begin
         errors++;
         $display("FAIL jalr_wb: state=%0d PCSel=%0b ASel=%0b ImmSel=%0d WBSel=%0d expected 5/1/0/0/2", state_o, PCSel, ASel, ImmSel, WBSel);
      end
      start(5'b11001, 3'b001, 1'b0);
      checks++;
      if (state_o !== 3'd6 || trap_cause !== 2'd1) begin
         errors++;
         $display("FAIL jalr_bad_f3: state=%0d cause=%0d expected 6/1", state_o, trap_cause);
      end
   endtask

   task automatic test_illegal();
      int bad = 0;
      start(5'b11111, 3'b000, 1'b0);
      checks++;
      if (state_o !== 3'd6 || trap !== 1'b1 || trap_cause !== 2'd1) begin
         errors++;
         $display("FAIL illegal_trap: state=%0d trap=%0b cause=%0d expected 6/1/1", state_o, trap, trap_cause);
      end
      for (int i = 0; i < 22; i++) begin
         tick();
         if (imem_req !== 1'b0 || state_o !== 3'd6 || PCWrite !== 1'b0 || trap !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL illegal_stays: bad_cycles=%0d expected 0", bad);
      end
   endtask

   task automatic test_imem_timeout();
      int bad = 0;
      rst = 1'b1; imem_ready = 1'b0; opcode = 5'b01100; func_3 = '0; func_7 = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      for (int i = 0; i < 9; i++) begin
         if (state_o !== 3'd1 || imem_req !== 1'b1) bad++;
         if (i < 8) tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL imem_wait: bad_cycles=%0d expected 0", bad);
      end
      tick();
      checks++;
      if (state_o !== 3'd6 || trap_cause !== 2'd2 || trap !== 1'b1 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL imem_timeout: state=%0d cause=%0d trap=%0b imem_req=%0b expected 6/2/1/0", state_o, trap_cause, trap, imem_req);
      end
      // ready arriving in the limit cycle still completes the fetch
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) tick();
      imem_ready = 1'b1;
      #1;
      checks++;
      if (state_o !== 3'd1 || IRWrite !== 1'b1) begin
         errors++;
         $display("FAIL imem_ready_wins: state=%0d IRWrite=%0b expected 1/1", state_o, IRWrite);
      end
      tick();
      checks++;
      if (state_o !== 3'd2 || trap !== 1'b0) begin
         errors++;
         $display("FAIL imem_ready_wins_next: state=%0d trap=%0b expected 2/0", state_o, trap);
      end
   endtask

   task automatic test_dmem_timeout();
      dmem_ready = 1'b0;
      start(5'b01000, 3'b010, 1'b0);
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (state_o !== 3'd4 || dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL dmem_wait: state=%0d dmem_req=%0b expected 4/1", state_o, dmem_req);
      end
      tick();
      checks++;
      if (state_o !== 3'd6 || trap_cause !== 2'd3 || dmem_req !== 1'b0 || MemRW !== 1'b0) begin
         errors++;
         $display("FAIL dmem_timeout: state=%0d cause=%0d dmem_req=%0b MemRW=%0b expected 6/3/0/0", state_o, trap_cause, dmem_req, MemRW);
      end
   endtask

   task automatic test_reset_mid_mem();
      dmem_ready = 1'b0;
      start(5'b01000, 3'b010, 1'b0);
      tick();
      checks++;
      if (state_o !== 3'd4 || dmem_req !== 1'b1 || MemRW !== 1'b1) begin
         errors++;
         $display("FAIL sw_mid_mem: state=%0d dmem_req=%0b MemRW=%0b expected 4/1/1", state_o, dmem_req, MemRW);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (dmem_req !== 1'b0 || MemRW !== 1'b0 || PCWrite !== 1'b0 || state_o !== 3'd0) begin
         errors++;
         $display("FAIL async_reset: dmem_req=%0b MemRW=%0b PCWrite=%0b state=%0d expected 0/0/0/0", dmem_req, MemRW, PCWrite, state_o);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (state_o !== 3'd0 || trap !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: state=%0d trap=%0b expected 0/0", state_o, trap);
      end
      tick();
      checks++;
      if (state_o !== 3'd1) begin
         errors++;
         $display("FAIL reset_to_fetch: state=%0d expected 1", state_o);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu_ops();
      test_load();
      test_store();
      test_branch();
      test_jumps();
      test_illegal();
      test_imem_timeout();
      test_dmem_timeout();
      test_reset_mid_mem();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
